// File: rtl/alu_seq_if.sv
// Host, instruction and downstream-ALU signal bundle for alu_seq.
// The slave side is the sequencer; the master side is host plus ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             instr_valid;
    logic             instr_ready;
    logic [7:0]       instr;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [1:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [1:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             done;
    logic [WIDTH-1:0] done_data;

    modport master (
        output instr_valid, instr,
        output wr_en, wr_addr, wr_data, rd_addr,
        output alu_result,
        input  instr_ready, rd_data,
        input  alu_opcode, alu_a, alu_b,
        input  done, done_data
    );

    modport slave (
        input  instr_valid, instr,
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  alu_result,
        output instr_ready, rd_data,
        output alu_opcode, alu_a, alu_b,
        output done, done_data
    );
endinterface

// File: rtl/alu_seq.sv
// Three-state instruction sequencer: register file, operand issue to an
// external ALU, result capture and writeback.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] regs [NREGS];
    logic [1:0]       rd_idx;
    logic [WIDTH-1:0] result;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             accept;
    logic             ready;
    logic             wb;

    assign accept = bus.instr_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        wb    = 1'b0;
        unique case (state)
            IDLE:    ready = 1'b1;
            WB:      wb    = 1'b1;
            default: ;
        endcase
    end

    // Operands come from pre-edge register contents, so a write landing
    // on the accept edge is invisible to the instruction being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode <= '0;
            op_a   <= '0;
            op_b   <= '0;
            rd_idx <= '0;
        end else if (accept) begin
            opcode <= bus.instr[7:6];
            rd_idx <= bus.instr[5:4];
            op_a   <= regs[bus.instr[3:2]];
            op_b   <= regs[bus.instr[1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            result <= '0;
        else if (state == EXEC) result <= bus.alu_result;
    end

    // Writeback is issued last so it wins over a host write to the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
            if (wb)        regs[rd_idx]      <= result;
        end
    end

    assign bus.instr_ready = ready;
    assign bus.done        = wb;
    assign bus.done_data   = result;
    assign bus.rd_data     = regs[bus.rd_addr];
    assign bus.alu_opcode  = opcode;
    assign bus.alu_a       = op_a;
    assign bus.alu_b       = op_b;
endmodule
